mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 61 ++++++
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Fetch / data / memory handshake bundle for mem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
   parameter int XLEN = 32
);
   logic            if_req_valid;
   logic [XLEN-1:0] if_req_addr;
   logic            if_req_ready;
   logic            if_rsp_valid;
   logic [XLEN-1:0] if_rsp_data;

   logic            dm_req_valid;
   logic            dm_req_we;
   logic [XLEN-1:0] dm_req_addr;
   logic [XLEN-1:0] dm_req_wdata;
   logic [3:0]      dm_req_be;
   logic            dm_req_ready;
   logic            dm_rsp_valid;
   logic [XLEN-1:0] dm_rsp_rdata;

   logic            mem_req_valid;
   logic            mem_req_ready;
   logic            mem_we;
   logic [XLEN-1:0] mem_addr;
   logic [XLEN-1:0] mem_wdata;
   logic [3:0]      mem_be;
   logic            mem_rsp_valid;
   logic [XLEN-1:0] mem_rsp_rdata;

   logic            stall_if;
   logic            stall_mem;

   // Arbiter side
   modport slave (
      input  if_req_valid, if_req_addr,
      output if_req_ready, if_rsp_valid, if_rsp_data,
      input  dm_req_valid, dm_req_we, dm_req_addr, dm_req_wdata, dm_req_be,
      output dm_req_ready, dm_rsp_valid, dm_rsp_rdata,
      output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_be,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
      output stall_if, stall_mem
   );

   // Pipeline / memory environment side
   modport master (
      output if_req_valid, if_req_addr,
      input  if_req_ready, if_rsp_valid, if_rsp_data,
      output dm_req_valid, dm_req_we, dm_req_addr, dm_req_wdata, dm_req_be,
      input  dm_req_ready, dm_rsp_valid, dm_rsp_rdata,
      input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_be,
      output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
      input  stall_if, stall_mem
   );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-ported memory between fetch and data ports,
//               one outstanding transaction, data priority with starvation cap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
   parameter int XLEN         = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic               clk,
   input  logic               rst,
   mem_port_arbiter_if.slave  bus
);
   localparam logic [3:0] C_LIMIT = 4'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RSP  = 2'd2
   } state_t;

   state_t          state_q;
   logic            owner_q;      // 1 = data port owns the transaction
   logic            we_q;
   logic [XLEN-1:0] addr_q;
   logic [XLEN-1:0] wdata_q;
   logic [3:0]      be_q;
   logic [3:0]      starve_q;
   logic [3:0]      starve_d;
   logic            mem_req_valid_q;

   logic w_idle;
   logic w_grant_dm;
   logic w_grant_if;
   logic w_rsp_fire;

   assign w_idle     = (state_q == S_IDLE) && !rst;
   assign w_grant_dm = w_idle && bus.dm_req_valid &&
                       !(bus.if_req_valid && (starve_q == C_LIMIT));
   assign w_grant_if = w_idle && bus.if_req_valid && !w_grant_dm;
   assign w_rsp_fire = (state_q == S_RSP) && bus.mem_rsp_valid;

   always_comb begin
      starve_d = starve_q;
      if (w_grant_if) begin
         starve_d = 4'd0;
      end else if (w_grant_dm && bus.if_req_valid && (starve_q < C_LIMIT)) begin
         starve_d = starve_q + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= S_IDLE;
         owner_q         <= 1'b0;
         we_q            <= 1'b0;
         addr_q          <= '0;
         wdata_q         <= '0;
         be_q            <= 4'd0;
         starve_q        <= 4'd0;
         mem_req_valid_q <= 1'b0;
      end else begin
         starve_q <= starve_d;
         case (state_q)
            S_IDLE: begin
               if (w_grant_dm || w_grant_if) begin
                  owner_q         <= w_grant_dm;
                  we_q            <= w_grant_dm && bus.dm_req_we;
                  addr_q          <= w_grant_dm ? bus.dm_req_addr  : bus.if_req_addr;
                  wdata_q         <= w_grant_dm ? bus.dm_req_wdata : '0;
                  be_q            <= w_grant_dm ? bus.dm_req_be    : 4'hF;
                  mem_req_valid_q <= 1'b1;
                  state_q         <= S_REQ;
               end
            end
            S_REQ: begin
               if (bus.mem_req_ready) begin
                  mem_req_valid_q <= 1'b0;
                  state_q         <= S_RSP;
               end
            end
            S_RSP: begin
               // Stores also wait here: the response doubles as write acknowledge.
               if (bus.mem_rsp_valid) begin
                  state_q <= S_IDLE;
               end
            end
            default: begin
               mem_req_valid_q <= 1'b0;
               state_q         <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.if_req_ready  = w_grant_if;
   assign bus.dm_req_ready  = w_grant_dm;

   assign bus.mem_req_valid = mem_req_valid_q;
   assign bus.mem_we        = we_q;
   assign bus.mem_addr      = addr_q;
   assign bus.mem_wdata     = wdata_q;
   assign bus.mem_be        = be_q;

   assign bus.if_rsp_valid  = w_rsp_fire && !owner_q;
   assign bus.if_rsp_data   = (w_rsp_fire && !owner_q) ? bus.mem_rsp_rdata : '0;
   assign bus.dm_rsp_valid  = w_rsp_fire && owner_q;
   assign bus.dm_rsp_rdata  = (w_rsp_fire && owner_q) ? bus.mem_rsp_rdata : '0;

   assign bus.stall_if  = !rst && bus.if_req_valid &&
                          !(w_grant_if || (w_rsp_fire && !owner_q));
   assign bus.stall_mem = !rst && bus.dm_req_valid &&
                          !(w_grant_dm || (w_rsp_fire && owner_q));

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench with response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;
   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;
   int   tb_starve;
   logic [32:0] sb[$];   // {owner_is_data, expected rdata}

   mem_port_arbiter_if #(.XLEN(32)) bus ();

   mem_port_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [31:0] mem_model(input logic [31:0] a);
      return (a == 32'h100) ? 32'h0000_0013 : (a ^ 32'h5A5A_0000);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One complete transaction: request, grant, optional ready/response delay.
   task automatic txn(input logic ifv, input logic dmv, input logic we,
                      input logic [31:0] ia, input logic [31:0] da,
                      input logic [31:0] wd, input logic [3:0] be,
                      input int rdy_dly, input int rsp_dly,
                      input logic keep_if, input logic keep_dm, input string tag);
      logic        exp_dm;
      logic        store;
      logic [31:0] eaddr;
      logic [32:0] exp;
      bus.if_req_valid = ifv;
      bus.if_req_addr  = ia;
      bus.dm_req_valid = dmv;
      bus.dm_req_we    = we;
      bus.dm_req_addr  = da;
      bus.dm_req_wdata = wd;
      bus.dm_req_be    = be;
      #1;
      exp_dm = dmv && !(ifv && tb_starve == 4);
      store  = exp_dm && we;
      eaddr  = exp_dm ? da : ia;
      chk({tag, " if_req_ready"}, 32'(bus.if_req_ready), 32'(!exp_dm));
      chk({tag, " dm_req_ready"}, 32'(bus.dm_req_ready), 32'(exp_dm));
      if (ifv) chk({tag, " stall_if@grant"}, 32'(bus.stall_if), 32'(exp_dm));
      if (dmv) chk({tag, " stall_mem@grant"}, 32'(bus.stall_mem), 32'(!exp_dm));
      sb.push_back({exp_dm, mem_model(eaddr)});
      if (!exp_dm) tb_starve = 0;
      else if (ifv && tb_starve < 4) tb_starve++;
      step();
      bus.if_req_valid = keep_if;
      bus.dm_req_valid = keep_dm;
      #1;
      chk({tag, " starve_cnt"}, 32'(dut.starve_q), 32'(tb_starve));
      for (int i = 0; i <= rdy_dly; i++) begin
         chk({tag, " mem_req_valid"}, 32'(bus.mem_req_valid), 32'd1);
         chk({tag, " mem_addr"}, bus.mem_addr, eaddr);
         chk({tag, " mem_we"}, 32'(bus.mem_we), 32'(store));
         if (store) begin
            chk({tag, " mem_wdata"}, bus.mem_wdata, wd);
            chk({tag, " mem_be"}, 32'(bus.mem_be), 32'(be));
         end
         if (keep_if && !exp_dm) chk({tag, " stall_if@req"}, 32'(bus.stall_if), 32'd1);
         if (i < rdy_dly) step();
      end
      bus.mem_req_ready = 1'b1;
      step();
      bus.mem_req_ready = 1'b0;
      #1;
      chk({tag, " mem_req_valid@rsp"}, 32'(bus.mem_req_valid), 32'd0);
      for (int i = 0; i < rsp_dly; i++) begin
         chk({tag, " early if_rsp_valid"}, 32'(bus.if_rsp_valid), 32'd0);
         chk({tag, " early dm_rsp_valid"}, 32'(bus.dm_rsp_valid), 32'd0);
         chk({tag, " early rsp_data"}, bus.if_rsp_data | bus.dm_rsp_rdata, 32'd0);
         step();
      end
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_rdata = mem_model(eaddr);
      #1;
      if (sb.size() == 0) begin
         chk({tag, " scoreboard empty"}, 32'd0, 32'd1);
      end else begin
         exp = sb.pop_front();
         chk({tag, " if_rsp_valid"}, 32'(bus.if_rsp_valid), 32'(!exp[32]));
         chk({tag, " dm_rsp_valid"}, 32'(bus.dm_rsp_valid), 32'(exp[32]));
         chk({tag, " owner rsp_data"}, exp[32] ? bus.dm_rsp_rdata : bus.if_rsp_data, exp[31:0]);
         chk({tag, " other rsp_data"}, exp[32] ? bus.if_rsp_data : bus.dm_rsp_rdata, 32'd0);
         if (keep_if && !exp[32]) chk({tag, " stall_if@rsp"}, 32'(bus.stall_if), 32'd0);
         if (keep_dm && exp[32]) chk({tag, " stall_mem@rsp"}, 32'(bus.stall_mem), 32'd0);
      end
      step();
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_rdata = '0;
      bus.if_req_valid  = 1'b0;
      bus.dm_req_valid  = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      tb_starve = 0;
      rst = 1'b1;
      bus.if_req_valid  = 1'b1;
      bus.if_req_addr   = 32'h100;
      bus.dm_req_valid  = 1'b1;
      bus.dm_req_we     = 1'b0;
      bus.dm_req_addr   = '0;
      bus.dm_req_wdata  = '0;
      bus.dm_req_be     = '0;
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_rdata = '0;

      // Reset: everything quiet even with requests pending
      step();
      chk("rst if_req_ready", 32'(bus.if_req_ready), 32'd0);
      chk("rst dm_req_ready", 32'(bus.dm_req_ready), 32'd0);
      chk("rst stall_if", 32'(bus.stall_if), 32'd0);
      chk("rst mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
      chk("rst mem_addr", bus.mem_addr, 32'd0);
      bus.if_req_valid = 1'b0;
      bus.dm_req_valid = 1'b0;
      rst = 1'b0;

      // Fetch only, immediate ready and response
      txn(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 4'h0, 0, 0, 1'b1, 1'b0, "fetch0x100");

      // Both valid: data wins four times, then fetch is forced through
      for (int k = 0; k < 5; k++)
         txn(1'b1, 1'b1, 1'b0, 32'h200 + 32'(k * 4), 32'h8000 + 32'(k * 4),
             32'h0, 4'hF, 0, 1, 1'b1, 1'b1, "starve");
      chk("starve cleared", 32'(dut.starve_q), 32'd0);

      // Data alone does not bump the starvation counter
      txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h4444, 32'h0, 4'hF, 1, 0, 1'b0, 1'b0, "load_only");

      // Store with mem_req_ready held low three cycles
      txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h9000, 32'hDEAD_BEEF, 4'b0011, 3, 2, 1'b0, 1'b1, "store");

      // Reset while in RSP abandons the transaction
      bus.if_req_valid = 1'b1;
      bus.if_req_addr  = 32'h300;
      step();
      bus.if_req_valid  = 1'b0;
      bus.mem_req_ready = 1'b1;
      step();
      bus.mem_req_ready = 1'b0;
      #1;
      rst = 1'b1;
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_rdata = 32'h1234_5678;
      #1;
      chk("rstRSP if_rsp_valid", 32'(bus.if_rsp_valid), 32'd0);
      chk("rstRSP mem_addr", bus.mem_addr, 32'd0);
      chk("rstRSP starve", 32'(dut.starve_q), 32'd0);
      tb_starve = 0;
      step();
      rst = 1'b0;
      step();
      chk("late if_rsp_valid", 32'(bus.if_rsp_valid), 32'd0);
      chk("late dm_rsp_valid", 32'(bus.dm_rsp_valid), 32'd0);
      chk("late rsp_data", bus.if_rsp_data | bus.dm_rsp_rdata, 32'd0);
      chk("late mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_rdata = '0;
      txn(1'b1, 1'b0, 1'b0, 32'h304, 32'h0, 32'h0, 4'h0, 0, 0, 1'b1, 1'b0, "after_rst");

      // Stray response in IDLE is ignored
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_rdata = 32'hFFFF_FFFF;
      #1;
      chk("idle if_rsp_valid", 32'(bus.if_rsp_valid), 32'd0);
      chk("idle dm_rsp_valid", 32'(bus.dm_rsp_valid), 32'd0);
      chk("idle rsp_data", bus.if_rsp_data | bus.dm_rsp_rdata, 32'd0);
      step();
      bus.mem_rsp_valid = 1'b0;
      #1;
      chk("idle mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
      txn(1'b1, 1'b1, 1'b0, 32'h400, 32'hA000, 32'h0, 4'hF, 0, 0, 1'b0, 1'b0, "after_stray");

      chk("scoreboard drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

`default_nettype wire
